ext_intf_sender: RTL and testbench

//  Master-side end of the external transaction interface. Accepts one 32-bit bus

---
 rtl/ext_intf_pkg.sv | 35 +++
 rtl/ext_intf_sender_if.sv | 43 ++++
 rtl/ext_intf_rdat_asm.sv | 65 ++++++
 rtl/ext_intf_sender.sv | 180 ++++++++++++++++++
 tb/tb_ext_intf_sender.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_intf_pkg.sv
// Shared phase codes, FSM states and CNTR-beat layout for the
// external transaction interface sender.
package ext_intf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNTR,
      ST_ADDR0,
      ST_ADDR1,
      ST_WDAT0,
      ST_WDAT1,
      ST_RWAIT,
      ST_DONE
   } state_t;

   localparam logic [2:0] PH_CNTR  = 3'd0;
   localparam logic [2:0] PH_ADDR0 = 3'd1;
   localparam logic [2:0] PH_ADDR1 = 3'd2;
   localparam logic [2:0] PH_WDAT0 = 3'd3;
   localparam logic [2:0] PH_WDAT1 = 3'd4;

   localparam int CNTR_WT    = 4;
   localparam int CNTR_BE_HI = 3;
   localparam int CNTR_BE_LO = 0;

   function automatic logic [15:0] cntr_word(input logic       wt,
                                             input logic [3:0] be);
      logic [15:0] w;
      w                         = '0;
      w[CNTR_WT]                = wt;
      w[CNTR_BE_HI:CNTR_BE_LO]  = be;
      return w;
   endfunction

endpackage

// File: rtl/ext_intf_sender_if.sv
// Local master port plus external TRANS/RESP channels.
// master = sender view, slave = master-wrapper / receiver view.
interface ext_intf_sender_if;

   logic        MCx_REQ;
   logic        MCx_WT;
   logic [3:0]  MCx_BE;
   logic [31:0] MCx_ADDR;
   logic [31:0] MCx_WDT;
   logic        MCx_nWAIT;
   logic        MCx_FAULT;
   logic        MCx_TimeOut;
   logic [31:0] MCx_RDT;

   logic        Ext_TRANS_VALID;
   logic [2:0]  Ext_TRANS_PHASE;
   logic [15:0] Ext_TRANS_DATA;
   logic        Ext_TRANS_ACK;

   logic        Ext_RESP_VALID;
   logic        Ext_RESP_RESP;
   logic [7:0]  Ext_RESP_DATA;
   logic        Ext_RESP_ACK;

   modport master (
      input  MCx_REQ, MCx_WT, MCx_BE, MCx_ADDR, MCx_WDT,
      output MCx_nWAIT, MCx_FAULT, MCx_TimeOut, MCx_RDT,
      output Ext_TRANS_VALID, Ext_TRANS_PHASE, Ext_TRANS_DATA,
      input  Ext_TRANS_ACK,
      input  Ext_RESP_VALID, Ext_RESP_RESP, Ext_RESP_DATA,
      output Ext_RESP_ACK
   );

   modport slave (
      output MCx_REQ, MCx_WT, MCx_BE, MCx_ADDR, MCx_WDT,
      input  MCx_nWAIT, MCx_FAULT, MCx_TimeOut, MCx_RDT,
      input  Ext_TRANS_VALID, Ext_TRANS_PHASE, Ext_TRANS_DATA,
      output Ext_TRANS_ACK,
      output Ext_RESP_VALID, Ext_RESP_RESP, Ext_RESP_DATA,
      input  Ext_RESP_ACK
   );

endinterface

// File: rtl/ext_intf_rdat_asm.sv
// Read-response assembler: byte counter, RDT placement, fault OR, RESP_ACK.
// EXT_INTF_SENDER_TIMEOUT_EN adds the late-byte discard counter.
module ext_intf_rdat_asm (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        clr,
   input  logic        en,
`ifdef EXT_INTF_SENDER_TIMEOUT_EN
   input  logic        abort,
   output logic        busy,
`endif
   input  logic        resp_valid,
   input  logic        resp_resp,
   input  logic [7:0]  resp_data,
   output logic        resp_ack,
   output logic        pop,
   output logic        last,
   output logic [31:0] rdt,
   output logic        fault
);

   logic [1:0] k;
   logic       drain;

`ifdef EXT_INTF_SENDER_TIMEOUT_EN
   logic [2:0] disc;

   assign drain = |disc;
   assign busy  = drain;

   // Bytes still owed by an abandoned read are swallowed before any new read
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         disc <= '0;
      end else if (abort) begin
         disc <= 3'd4 - {1'b0, k};
      end else if (drain && resp_valid) begin
         disc <= disc - 3'd1;
      end
   end
`else
   assign drain = 1'b0;
`endif

   assign pop      = en & ~drain & resp_valid;
   assign resp_ack = resp_valid & (en | drain);
   assign last     = pop & (k == 2'd3);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         k     <= '0;
         rdt   <= '0;
         fault <= 1'b0;
      end else if (clr) begin
         k     <= '0;
         rdt   <= '0;
         fault <= 1'b0;
      end else if (pop) begin
         rdt[{k, 3'b000} +: 8] <= resp_data;
         fault                 <= fault | resp_resp;
         k                     <= k + 2'd1;
      end
   end

endmodule

// File: rtl/ext_intf_sender.sv
// Master-side sender: serialises one bus request into phase-tagged beats
// and collects read bytes. Optional timeout: EXT_INTF_SENDER_TIMEOUT_EN.
module ext_intf_sender
   import ext_intf_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_CNT_W       = 9
) (
   input logic              CLK,
   input logic              nRST,
   ext_intf_sender_if.master ext
);

   if ((64'd1 << TO_CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_err
      $error("TO_CNT_W too narrow for TIMEOUT_CYCLES");
   end

   state_t      state;
   logic        wt;
   logic [31:0] addr;
   logic [31:0] wdt;
   logic        nwait;
   logic        valid;
   logic [2:0]  phase;
   logic [15:0] data;

   logic        start;
   logic        in_rwait;
   logic        pop;
   logic        last;
   logic [31:0] rdt;
   logic        fault;
   logic        to_hit;
   logic        to_flag;

   assign start    = (state == ST_IDLE) & ext.MCx_REQ;
   assign in_rwait = (state == ST_RWAIT);

`ifdef EXT_INTF_SENDER_TIMEOUT_EN
   logic                busy;
   logic [TO_CNT_W-1:0] to_cnt;

   assign to_hit = in_rwait & ~pop & ~busy &
                   (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts silent RWAIT cycles; any popped byte restarts the window
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         to_cnt <= '0;
      end else if (!in_rwait || pop || busy) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         to_flag <= 1'b0;
      end else if (start) begin
         to_flag <= 1'b0;
      end else if (to_hit) begin
         to_flag <= 1'b1;
      end
   end
`else
   assign to_hit  = 1'b0;
   assign to_flag = 1'b0;
`endif

   ext_intf_rdat_asm u_asm (
      .CLK        (CLK),
      .nRST       (nRST),
      .clr        (start),
      .en         (in_rwait),
`ifdef EXT_INTF_SENDER_TIMEOUT_EN
      .abort      (to_hit),
      .busy       (busy),
`endif
      .resp_valid (ext.Ext_RESP_VALID),
      .resp_resp  (ext.Ext_RESP_RESP),
      .resp_data  (ext.Ext_RESP_DATA),
      .resp_ack   (ext.Ext_RESP_ACK),
      .pop        (pop),
      .last       (last),
      .rdt        (rdt),
      .fault      (fault)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= ST_IDLE;
         wt    <= 1'b0;
         addr  <= '0;
         wdt   <= '0;
         nwait <= 1'b0;
         valid <= 1'b0;
         phase <= '0;
         data  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (ext.MCx_REQ) begin
                  wt    <= ext.MCx_WT;
                  addr  <= ext.MCx_ADDR;
                  wdt   <= ext.MCx_WDT;
                  valid <= 1'b1;
                  phase <= PH_CNTR;
                  data  <= cntr_word(ext.MCx_WT, ext.MCx_BE);
                  state <= ST_CNTR;
               end
            end
            ST_CNTR: begin
               if (ext.Ext_TRANS_ACK) begin
                  phase <= PH_ADDR0;
                  data  <= addr[15:0];
                  state <= ST_ADDR0;
               end
            end
            ST_ADDR0: begin
               if (ext.Ext_TRANS_ACK) begin
                  phase <= PH_ADDR1;
                  data  <= addr[31:16];
                  state <= ST_ADDR1;
               end
            end
            ST_ADDR1: begin
               if (ext.Ext_TRANS_ACK) begin
                  if (wt) begin
                     phase <= PH_WDAT0;
                     data  <= wdt[15:0];
                     state <= ST_WDAT0;
                  end else begin
                     valid <= 1'b0;
                     phase <= '0;
                     data  <= '0;
                     state <= ST_RWAIT;
                  end
               end
            end
            ST_WDAT0: begin
               if (ext.Ext_TRANS_ACK) begin
                  phase <= PH_WDAT1;
                  data  <= wdt[31:16];
                  state <= ST_WDAT1;
               end
            end
            ST_WDAT1: begin
               if (ext.Ext_TRANS_ACK) begin
                  valid <= 1'b0;
                  phase <= '0;
                  data  <= '0;
                  nwait <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_RWAIT: begin
               if (last || to_hit) begin
                  nwait <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               nwait <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ext.MCx_nWAIT       = nwait;
   assign ext.MCx_FAULT       = nwait & (to_flag | (~wt & fault));
   assign ext.MCx_TimeOut     = nwait & to_flag;
   assign ext.MCx_RDT         = rdt;
   assign ext.Ext_TRANS_VALID = valid;
   assign ext.Ext_TRANS_PHASE = phase;
   assign ext.Ext_TRANS_DATA  = data;

endmodule

// File: tb/tb_ext_intf_sender.sv
// Directed bench for ext_intf_sender: beat order, read assembly,
// ACK stalls, faults, async reset and (with timeout build) late-byte discard.
module tb_ext_intf_sender;

   localparam int TO_CYC = 16;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   ext_intf_sender_if bus ();

   ext_intf_sender #(
      .TIMEOUT_CYCLES (TO_CYC),
      .TO_CNT_W       (5)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .ext  (bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always @(posedge CLK) cyc++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
   endtask

   logic [18:0] beats[$];
   int          last_beat_cyc = 0;
   int          pop_cyc = 0;
   int          stab_viol = 0;
   int          ack_viol = 0;
   logic        prev_stall = 1'b0;
   logic [18:0] prev_beat = '0;

   always @(negedge CLK) begin
      if (bus.Ext_RESP_ACK && !bus.Ext_RESP_VALID) ack_viol++;
      if (bus.Ext_RESP_ACK) pop_cyc = cyc;
      if (prev_stall && (!bus.Ext_TRANS_VALID ||
          {bus.Ext_TRANS_PHASE, bus.Ext_TRANS_DATA} != prev_beat))
         stab_viol++;
      prev_stall = nRST & bus.Ext_TRANS_VALID & ~bus.Ext_TRANS_ACK;
      prev_beat  = {bus.Ext_TRANS_PHASE, bus.Ext_TRANS_DATA};
      if (bus.Ext_TRANS_VALID && bus.Ext_TRANS_ACK) begin
         beats.push_back({bus.Ext_TRANS_PHASE, bus.Ext_TRANS_DATA});
         last_beat_cyc = cyc;
      end
   end

   int ack_mode = 0;
   int hold = 0;

   always @(posedge CLK) begin
      #1;
      if (ack_mode == 1) begin
         if (bus.Ext_TRANS_VALID && bus.Ext_TRANS_PHASE == 3'd2 && hold < 5) begin
            bus.Ext_TRANS_ACK = 1'b0;
            hold++;
         end else begin
            bus.Ext_TRANS_ACK = 1'($urandom_range(0, 1));
         end
      end else begin
         bus.Ext_TRANS_ACK = 1'b1;
      end
   end

   logic [31:0] got_rdt;
   logic        got_fault;
   logic        got_to;
   int          nw_cyc;

   task automatic send_req(input logic wt, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d);
      bit seen;
      seen = 0;
      @(negedge CLK);
      bus.MCx_WT   = wt;
      bus.MCx_BE   = be;
      bus.MCx_ADDR = a;
      bus.MCx_WDT  = d;
      bus.MCx_REQ  = 1'b1;
      for (int t = 0; t < 400 && !seen; t++) begin
         @(negedge CLK);
         if (bus.MCx_nWAIT) begin
            seen      = 1;
            nw_cyc    = cyc;
            got_rdt   = bus.MCx_RDT;
            got_fault = bus.MCx_FAULT;
            got_to    = bus.MCx_TimeOut;
         end
      end
      bus.MCx_REQ = 1'b0;
      if (!seen) begin
         chk("nwait_wait", 32'(seen), 32'd1);
      end else begin
         @(negedge CLK);
         chk("nwait_pulse", 32'(bus.MCx_nWAIT), 32'd0);
      end
   endtask

   task automatic send_resp(input logic [31:0] bytes, input logic [3:0] flt,
                            input int n, input int gap);
      bit ok;
      @(posedge CLK);
      #1;
      for (int i = 0; i < n; i++) begin
         bus.Ext_RESP_VALID = 1'b1;
         bus.Ext_RESP_DATA  = bytes[8*i +: 8];
         bus.Ext_RESP_RESP  = flt[i];
         ok = 0;
         for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge CLK);
            if (bus.Ext_RESP_ACK) ok = 1;
            @(posedge CLK);
            #1;
         end
         bus.Ext_RESP_VALID = 1'b0;
         bus.Ext_RESP_RESP  = 1'b0;
         chk("resp_ack", 32'(ok), 32'd1);
         repeat (gap) begin
            @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic chk_beats(input string tag, input logic [18:0] exp[$]);
      chk({tag, "_nbeats"}, 32'(beats.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i),
             32'(i < beats.size() ? beats[i] : 19'h7FFFF), 32'(exp[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      bit found;
      bus.MCx_REQ        = 1'b0;
      bus.MCx_WT         = 1'b0;
      bus.MCx_BE         = '0;
      bus.MCx_ADDR       = '0;
      bus.MCx_WDT        = '0;
      bus.Ext_TRANS_ACK  = 1'b1;
      bus.Ext_RESP_VALID = 1'b0;
      bus.Ext_RESP_RESP  = 1'b0;
      bus.Ext_RESP_DATA  = '0;

      repeat (2) @(negedge CLK);
      chk("rst_valid", 32'(bus.Ext_TRANS_VALID), 32'd0);
      chk("rst_nwait", 32'(bus.MCx_nWAIT), 32'd0);
      chk("rst_rdt", bus.MCx_RDT, 32'd0);
      chk("rst_respack", 32'(bus.Ext_RESP_ACK), 32'd0);
      chk("rst_fault", 32'(bus.MCx_FAULT), 32'd0);
      nRST = 1'b1;

      // 1: write, ACK tied high
      beats.delete();
      send_req(1'b1, 4'hF, 32'h1234_5678, 32'hCAFE_F00D);
      chk_beats("t1", '{{3'd0, 16'h001F}, {3'd1, 16'h5678}, {3'd2, 16'h1234},
                        {3'd3, 16'hF00D}, {3'd4, 16'hCAFE}});
      chk("t1_lat", 32'(nw_cyc - last_beat_cyc), 32'd1);
      chk("t1_fault", 32'(got_fault), 32'd0);
      chk("t1_to", 32'(got_to), 32'd0);

      // 2: plain read
      beats.delete();
      fork
         send_req(1'b0, 4'hF, 32'h0000_0040, 32'h0);
         send_resp(32'h4433_2211, 4'b0000, 4, 0);
      join
      chk_beats("t2", '{{3'd0, 16'h000F}, {3'd1, 16'h0040}, {3'd2, 16'h0000}});
      chk("t2_rdt", got_rdt, 32'h4433_2211);
      chk("t2_fault", 32'(got_fault), 32'd0);

      // 3: random ACK with 5-cycle stall on ADDR1
      beats.delete();
      hold = 0;
      ack_mode = 1;
      send_req(1'b1, 4'h3, 32'hA5A5_0F0F, 32'h1357_9BDF);
      ack_mode = 0;
      chk_beats("t3", '{{3'd0, 16'h0013}, {3'd1, 16'h0F0F}, {3'd2, 16'hA5A5},
                        {3'd3, 16'h9BDF}, {3'd4, 16'h1357}});
      chk("t3_hold", 32'(hold), 32'd5);
      chk("t3_stable", 32'(stab_viol), 32'd0);

      // 4: read, byte 2 faulted, gaps between bytes
      fork
         send_req(1'b0, 4'h1, 32'h0000_1000, 32'h0);
         send_resp(32'hEFBE_ADDE, 4'b0100, 4, 3);
      join
      chk("t4_rdt", got_rdt, 32'hEFBE_ADDE);
      chk("t4_fault", 32'(got_fault), 32'd1);
      chk("t4_ackvalid", 32'(ack_viol), 32'd0);

      // 5: async reset during WDAT0, then a normal read
      @(negedge CLK);
      bus.MCx_WT   = 1'b1;
      bus.MCx_BE   = 4'hF;
      bus.MCx_ADDR = 32'h0000_0100;
      bus.MCx_WDT  = 32'h5555_AAAA;
      bus.MCx_REQ  = 1'b1;
      found = 0;
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge CLK);
         if (bus.Ext_TRANS_VALID && bus.Ext_TRANS_PHASE == 3'd3) found = 1;
      end
      chk("t5_reach_wdat0", 32'(found), 32'd1);
      #2 nRST = 1'b0;
      #1;
      chk("t5_valid", 32'(bus.Ext_TRANS_VALID), 32'd0);
      chk("t5_phase_data", {13'd0, bus.Ext_TRANS_PHASE, bus.Ext_TRANS_DATA}, 32'd0);
      chk("t5_nwait", 32'(bus.MCx_nWAIT), 32'd0);
      chk("t5_rdt", bus.MCx_RDT, 32'd0);
      bus.MCx_REQ = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      fork
         send_req(1'b0, 4'hF, 32'h0000_0080, 32'h0);
         send_resp(32'h0403_0201, 4'b0000, 4, 1);
      join
      chk("t5_rdt_after", got_rdt, 32'h0403_0201);
      chk("t5_fault_after", 32'(got_fault), 32'd0);
      chk("t5_to_after", 32'(got_to), 32'd0);

`ifdef EXT_INTF_SENDER_TIMEOUT_EN
      // 6: one byte then silence; pop edge to DONE edge is TO_CYC cycles
      fork
         send_req(1'b0, 4'hF, 32'h0000_0044, 32'h0);
         send_resp(32'h0000_005A, 4'b0000, 1, 0);
      join
      chk("t6_to", 32'(got_to), 32'd1);
      chk("t6_fault", 32'(got_fault), 32'd1);
      chk("t6_rdt", got_rdt, 32'h0000_005A);
      chk("t6_lat", 32'(nw_cyc - pop_cyc), 32'(TO_CYC + 1));
      send_resp(32'h00C0_B0A0, 4'b0000, 3, 0);
      fork
         send_req(1'b0, 4'hF, 32'h0000_0048, 32'h0);
         send_resp(32'h4030_2010, 4'b0000, 4, 0);
      join
      chk("t6_rdt_next", got_rdt, 32'h4030_2010);
      chk("t6_to_next", 32'(got_to), 32'd0);
      chk("t6_fault_next", 32'(got_fault), 32'd0);
`endif

      repeat (2) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
